// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
// One transaction in flight: IDLE (grant/accept) -> EXEC (ALU settles)
// -> RESP (hold result until consumed) -> IDLE.
// Build option: define ALU_ARBITER_FIXED_PRIORITY_EN to make requester 0
// always win ties and drop the round-robin pointer.
module alu_arbiter #(
   parameter int BUS_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [7:0]             req_opcode,
   input  logic [2*BUS_WIDTH-1:0] req_a,
   input  logic [2*BUS_WIDTH-1:0] req_b,
   input  logic [1:0]             req_carry_in,
   output logic [BUS_WIDTH-1:0]   alu_a,
   output logic [BUS_WIDTH-1:0]   alu_b,
   output logic [3:0]             alu_opcode,
   output logic                   alu_carry_in,
   input  logic [BUS_WIDTH-1:0]   alu_y,
   input  logic                   alu_carry_out,
   input  logic                   alu_borrow,
   input  logic                   alu_zero,
   input  logic                   alu_parity,
   input  logic                   alu_invalid_op,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic                   rsp_id,
   output logic [BUS_WIDTH-1:0]   rsp_y,
   output logic [4:0]             rsp_flags,
   output logic                   busy
);

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

   state_t                 r_state;
   state_t                 w_next;
   logic                   w_tie_winner;
   logic                   w_gnt;
   logic                   w_accept;
   logic [3:0]             r_opcode;
   logic [BUS_WIDTH-1:0]   r_a;
   logic [BUS_WIDTH-1:0]   r_b;
   logic                   r_cin;
   logic                   r_id;
   logic [BUS_WIDTH-1:0]   r_y;
   logic [4:0]             r_flags;

`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
   assign w_tie_winner = 1'b0;
`else
   // Index of the last accepted requester; resets to 1 so requester 0
   // takes the first tie.
   logic r_last;

   assign w_tie_winner = ~r_last;

   // Pointer moves only when a request is actually accepted.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_last <= 1'b1;
      else if (w_accept)
         r_last <= w_gnt;
   end
`endif

   // Winner selection: tie goes to the arbitration choice, otherwise
   // whichever single requester is valid.
   always_comb begin
      w_gnt = 1'b0;
      if (req_valid == 2'b11)
         w_gnt = w_tie_winner;
      else
         w_gnt = req_valid[1];
   end

   // Grant is offered only in IDLE and never while reset is held.
   always_comb begin
      req_ready = 2'b00;
      if (!rst && r_state == S_IDLE && |req_valid)
         req_ready = w_gnt ? 2'b10 : 2'b01;
   end

   assign w_accept = |(req_valid & req_ready);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_next;
   end

   // Next-state logic: EXEC is a fixed single cycle, RESP waits on consumer.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_next = S_EXEC;
         S_EXEC:  w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Operand capture on acceptance; these drive the ALU in every state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opcode <= '0;
         r_a      <= '0;
         r_b      <= '0;
         r_cin    <= 1'b0;
         r_id     <= 1'b0;
      end else if (w_accept) begin
         r_opcode <= w_gnt ? req_opcode[7:4] : req_opcode[3:0];
         r_a      <= w_gnt ? req_a[2*BUS_WIDTH-1:BUS_WIDTH] : req_a[BUS_WIDTH-1:0];
         r_b      <= w_gnt ? req_b[2*BUS_WIDTH-1:BUS_WIDTH] : req_b[BUS_WIDTH-1:0];
         r_cin    <= w_gnt ? req_carry_in[1] : req_carry_in[0];
         r_id     <= w_gnt;
      end
   end

   // Result capture at the end of EXEC; held through RESP.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y     <= '0;
         r_flags <= '0;
      end else if (r_state == S_EXEC) begin
         r_y     <= alu_y;
         r_flags <= {alu_invalid_op, alu_parity, alu_zero, alu_borrow, alu_carry_out};
      end
   end

   assign alu_a        = r_a;
   assign alu_b        = r_b;
   assign alu_opcode   = r_opcode;
   assign alu_carry_in = r_cin;
   assign rsp_valid    = (r_state == S_RESP);
   assign rsp_id       = r_id;
   assign rsp_y        = r_y;
   assign rsp_flags    = r_flags;
   assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stand-in combinational ALU, table of single-requester
// vectors, plus sequences for arbitration, response stall and mid-flight reset.
module tb_alu_arbiter;
   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic [7:0]    req_opcode;
   logic [2*W-1:0] req_a, req_b;
   logic [1:0]    req_carry_in;
   logic [W-1:0]  alu_a, alu_b;
   logic [3:0]    alu_opcode;
   logic          alu_carry_in;
   logic [W-1:0]  m_y;
   logic          m_c, m_b, m_z, m_p, m_inv;
   logic          rsp_valid, rsp_ready, rsp_id, busy;
   logic [W-1:0]  rsp_y;
   logic [4:0]    rsp_flags;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic         id;
      logic [W-1:0] y;
      logic [4:0]   f;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      int          id;
      logic [3:0]  op;
      logic [7:0]  a, b;
      logic        cin;
      logic [7:0]  y;
      logic [4:0]  f;
   } vec_t;
   vec_t tbl[8];

   always #5 clk = ~clk;

   alu_arbiter #(.BUS_WIDTH(W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b),
      .req_carry_in(req_carry_in),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
      .alu_carry_in(alu_carry_in),
      .alu_y(m_y), .alu_carry_out(m_c), .alu_borrow(m_b), .alu_zero(m_z),
      .alu_parity(m_p), .alu_invalid_op(m_inv),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_y(rsp_y), .rsp_flags(rsp_flags), .busy(busy)
   );

   // Stand-in ALU: 0 pass, 1 add, 2 adc, 3 sub, 4 and, 5 or, 6 xor,
   // 7..F invalid (result 0). Parity reported over the low nibble.
   logic [W:0] t;
   always_comb begin
      t = '0; m_y = '0; m_c = 1'b0; m_b = 1'b0; m_inv = 1'b0;
      case (alu_opcode)
         4'h0: m_y = alu_a;
         4'h1: begin t = {1'b0, alu_a} + {1'b0, alu_b}; m_y = t[W-1:0]; m_c = t[W]; end
         4'h2: begin
            t = {1'b0, alu_a} + {1'b0, alu_b} + {{W{1'b0}}, alu_carry_in};
            m_y = t[W-1:0]; m_c = t[W];
         end
         4'h3: begin m_y = alu_a - alu_b; m_b = (alu_a < alu_b); end
         4'h4: m_y = alu_a & alu_b;
         4'h5: m_y = alu_a | alu_b;
         4'h6: m_y = alu_a ^ alu_b;
         default: begin m_y = '0; m_inv = 1'b1; end
      endcase
      m_z = (m_y == '0);
      m_p = ^m_y[3:0];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Response scoreboard: every consumed response must match the oldest
   // expectation pushed when its request was driven.
   always @(negedge clk) begin
      if (!rst && rsp_valid && rsp_ready) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected: got id=%0d y=%0h with nothing outstanding", rsp_id, rsp_y);
         end else begin
            sb_t e;
            e = sb_q.pop_front();
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_y", 32'(rsp_y), 32'(e.y));
            chk("rsp_flags", 32'(rsp_flags), 32'(e.f));
         end
      end
   end

   task automatic set_req(input int id, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin);
      if (id == 0) begin
         req_opcode[3:0] = op; req_a[7:0] = a; req_b[7:0] = b; req_carry_in[0] = cin;
      end else begin
         req_opcode[7:4] = op; req_a[15:8] = a; req_b[15:8] = b; req_carry_in[1] = cin;
      end
   endtask

   // Wait (bounded) at negedge+1 until any grant is offered.
   task automatic wait_ready();
      int n = 0;
      while (req_ready == 2'b00 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 20) begin
         checks++; errors++;
         $display("FAIL ready_timeout: got no grant expected a grant");
      end
   endtask

   // One request from a single requester with rsp_ready held high.
   task automatic txn(input vec_t v);
      set_req(v.id, v.op, v.a, v.b, v.cin);
      @(negedge clk);
      req_valid[v.id] = 1'b1;
      #1;
      wait_ready();
      chk("grant", 32'(req_ready), (v.id == 0) ? 32'd1 : 32'd2);
      sb_q.push_back(sb_t'{v.id[0], v.y, v.f});
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("exec_busy", 32'(busy), 32'd1);
      chk("exec_no_rsp", 32'(rsp_valid), 32'd0);
      chk("alu_a_hold", 32'(alu_a), 32'(v.a));
      @(negedge clk);
      chk("rsp_latency", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      chk("idle_after", 32'(busy), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      logic exp_g [4];
      logic [7:0] hold_y;
`ifdef ALU_ARBITER_FIXED_PRIORITY_EN
      exp_g = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
      tbl[0] = '{0, 4'h1, 8'h0F, 8'h01, 1'b0, 8'h10, 5'b00000};
      tbl[1] = '{1, 4'h2, 8'hFF, 8'h00, 1'b1, 8'h00, 5'b00101};
      tbl[2] = '{0, 4'hF, 8'h12, 8'h34, 1'b0, 8'h00, 5'b10100};
      tbl[3] = '{1, 4'h3, 8'h05, 8'h07, 1'b0, 8'hFE, 5'b01010};
      tbl[4] = '{0, 4'h4, 8'hF0, 8'h3C, 1'b0, 8'h30, 5'b00000};
      tbl[5] = '{1, 4'h6, 8'hAA, 8'hAA, 1'b0, 8'h00, 5'b00100};
      tbl[6] = '{0, 4'h1, 8'h80, 8'h80, 1'b0, 8'h00, 5'b00101};
      tbl[7] = '{1, 4'h5, 8'h01, 8'h00, 1'b0, 8'h01, 5'b01000};

      // Reset state, with requests pending to show grants are suppressed.
      rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b0;
      req_opcode = 8'h21; req_a = 16'h1234; req_b = 16'h5678; req_carry_in = 2'b11;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_alu", 32'({alu_a, alu_b, alu_opcode, alu_carry_in}), 32'd0);
      chk("rst_rsp", 32'({rsp_id, rsp_y, rsp_flags}), 32'd0);
      req_valid = 2'b00; rsp_ready = 1'b1;
      @(negedge clk); rst = 1'b0;

      for (int i = 0; i < 8; i++) txn(tbl[i]);

      // Both requesters held valid from reset.
      rst = 1'b1;
      set_req(0, 4'h1, 8'h03, 8'h04, 1'b0);
      set_req(1, 4'h4, 8'h0F, 8'h06, 1'b0);
      req_valid = 2'b11;
      @(negedge clk); rst = 1'b0;
      #1;
      for (int k = 0; k < 4; k++) begin
         wait_ready();
         chk("rr_grant", 32'(req_ready), exp_g[k] ? 32'd2 : 32'd1);
         if (exp_g[k]) sb_q.push_back(sb_t'{1'b1, 8'h06, 5'b00000});
         else          sb_q.push_back(sb_t'{1'b0, 8'h07, 5'b01000});
         @(posedge clk); #1;
         if (k == 3) req_valid = 2'b00;
      end
      repeat (3) @(negedge clk);
      chk("rr_drained", 32'(busy), 32'd0);

      // Consumer stalls RESP for five cycles; requester 1 pokes meanwhile.
      rsp_ready = 1'b0;
      set_req(0, 4'h1, 8'h20, 8'h22, 1'b0);
      @(negedge clk); req_valid = 2'b01; #1;
      wait_ready();
      chk("stall_grant", 32'(req_ready), 32'd1);
      sb_q.push_back(sb_t'{1'b0, 8'h42, 5'b01000});
      @(posedge clk); #1;
      req_valid = 2'b10;
      set_req(1, 4'h6, 8'h55, 8'h0F, 1'b0);
      @(negedge clk);
      @(negedge clk);
      hold_y = rsp_y;
      chk("stall_y_first", 32'(hold_y), 32'h42);
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", 32'(rsp_valid), 32'd1);
         chk("stall_y", 32'(rsp_y), 32'(hold_y));
         chk("stall_ready", 32'(req_ready), 32'd0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("stall_still_valid", 32'(rsp_valid), 32'd1);
      @(negedge clk);
      chk("stall_idle", 32'(busy), 32'd0);
      chk("idle_offer", 32'(req_ready), 32'd2);
      req_valid = 2'b00;
      @(negedge clk);
      chk("withdrawn_idle", 32'(busy), 32'd0);

      // Reset during EXEC discards the request and restores the pointer.
      set_req(0, 4'h1, 8'h01, 8'h01, 1'b0);
      set_req(1, 4'h3, 8'h05, 8'h07, 1'b0);
      @(negedge clk); req_valid = 2'b01; #1;
      wait_ready();
      @(posedge clk); #1;
      req_valid = 2'b00;
      @(negedge clk);
      chk("pre_rst_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      chk("async_rst_busy", 32'(busy), 32'd0);
      chk("async_rst_alu_a", 32'(alu_a), 32'd0);
      @(negedge clk); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("discarded_no_rsp", 32'(rsp_valid), 32'd0);
      end
      req_valid = 2'b11; #1;
      chk("tie_after_rst", 32'(req_ready), 32'd1);
      sb_q.push_back(sb_t'{1'b0, 8'h02, 5'b01000});
      @(posedge clk); #1;
      req_valid = 2'b00;
      repeat (4) @(negedge clk);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
